// File: rtl/phy_pkg.sv
// Shared PHY definitions: 4b5b table, K-codes, CRC-32 constants and the TX encoder FSM states.
// The CRC helpers are used by phy_crc32 when PHY_TX_CRC_EN is defined.
package phy_pkg;

    localparam logic [4:0] K_EOP   = 5'b01101;
    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC2 = 5'b10001;
    localparam logic [4:0] K_SYNC3 = 5'b00110;
    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StDataLo,
        StDataHi,
        StWaitByte,
        StCrc,
        StEop
    } phy_tx_state_e;

    function automatic logic [4:0] enc4b5b(input logic [3:0] nib);
        logic [4:0] sym;
        case (nib)
            4'h0: sym = 5'b11110;
            4'h1: sym = 5'b01001;
            4'h2: sym = 5'b10100;
            4'h3: sym = 5'b10101;
            4'h4: sym = 5'b01010;
            4'h5: sym = 5'b01011;
            4'h6: sym = 5'b01110;
            4'h7: sym = 5'b01111;
            4'h8: sym = 5'b10010;
            4'h9: sym = 5'b10011;
            4'hA: sym = 5'b10110;
            4'hB: sym = 5'b10111;
            4'hC: sym = 5'b11010;
            4'hD: sym = 5'b11011;
            4'hE: sym = 5'b11100;
            default: sym = 5'b11101;
        endcase
        return sym;
    endfunction

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [3:0] crc_nibble(input logic [31:0] crc_out, input logic [2:0] idx);
        return crc_out[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/phy_crc32.sv
// Byte-wise USB PD CRC-32 register; init has priority over update.
// Instantiated by phy_tx_sym_enc only when PHY_TX_CRC_EN is defined.
module phy_crc32
    import phy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        upd,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            r_crc <= CRC_INIT;
        end else if (upd) begin
            r_crc <= crc32_byte(r_crc, byte_in);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/phy_tx_sym_enc.sv
// USB PD TX symbol encoder: payload bytes -> 4b5b symbols, optional CRC-32 trailer, then EOP.
// Define PHY_TX_CRC_EN to insert the 8 CRC symbols; otherwise upstream supplies CRC bytes.
module phy_tx_sym_enc
    import phy_pkg::*;
#(
    parameter int unsigned SYM_W  = 5,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pl2phy_tx_payload_en,
    input  logic [BYTE_W-1:0] pl2phy_tx_payload,
    input  logic              pl2phy_tx_payload_last,
    output logic              phy2pl_tx_payload_done,
    input  logic              pl2phy_tx_abort,
    output logic              enc2ser_sym_vld,
    output logic [SYM_W-1:0]  enc2ser_sym,
    input  logic              ser2enc_sym_rdy,
    output logic              phy2pl_tx_frame_done
);

    phy_tx_state_e     r_state;
    logic              r_vld;
    logic [SYM_W-1:0]  r_sym;
    logic              r_done;
    logic              r_frame_done;
    logic [BYTE_W-1:0] r_byte;
    logic              r_last;
    logic              w_acc;

    assign w_acc = r_vld & ser2enc_sym_rdy;

`ifdef PHY_TX_CRC_EN
    logic [2:0]  r_cnt;
    logic [31:0] w_crc;
    logic [31:0] w_crc_out;
    logic        w_crc_init;
    logic        w_crc_upd;

    assign w_crc_init = pl2phy_tx_abort | ((r_state == StIdle) & pl2phy_tx_payload_en);
    assign w_crc_upd  = ~pl2phy_tx_abort & (r_state == StDataHi) & w_acc;
    assign w_crc_out  = ~w_crc;

    phy_crc32 u_crc (
        .clk     (clk),
        .rst     (rst),
        .init    (w_crc_init),
        .upd     (w_crc_upd),
        .byte_in (r_byte[7:0]),
        .crc     (w_crc)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst || pl2phy_tx_abort) begin
            r_state      <= StIdle;
            r_vld        <= 1'b0;
            r_sym        <= '0;
            r_done       <= 1'b0;
            r_frame_done <= 1'b0;
            r_byte       <= '0;
            r_last       <= 1'b0;
`ifdef PHY_TX_CRC_EN
            r_cnt        <= 3'd0;
`endif
        end else begin
            r_done       <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                StIdle, StWaitByte: begin
                    if (pl2phy_tx_payload_en) begin
                        r_byte  <= pl2phy_tx_payload;
                        r_last  <= pl2phy_tx_payload_last;
                        r_sym   <= enc4b5b(pl2phy_tx_payload[3:0]);
                        r_vld   <= 1'b1;
                        r_state <= StDataLo;
                    end
                end
                StDataLo: begin
                    if (w_acc) begin
                        r_sym   <= enc4b5b(r_byte[7:4]);
                        r_state <= StDataHi;
                    end
                end
                StDataHi: begin
                    if (w_acc) begin
                        r_done <= 1'b1;
                        if (r_last) begin
`ifdef PHY_TX_CRC_EN
                            // One idle cycle lets the CRC register absorb this byte.
                            r_vld   <= 1'b0;
                            r_cnt   <= 3'd0;
                            r_state <= StCrc;
`else
                            r_sym   <= K_EOP;
                            r_state <= StEop;
`endif
                        end else begin
                            r_vld   <= 1'b0;
                            r_state <= StWaitByte;
                        end
                    end
                end
`ifdef PHY_TX_CRC_EN
                StCrc: begin
                    if (!r_vld) begin
                        r_sym <= enc4b5b(crc_nibble(w_crc_out, r_cnt));
                        r_vld <= 1'b1;
                    end else if (w_acc) begin
                        if (r_cnt == 3'd7) begin
                            r_sym   <= K_EOP;
                            r_state <= StEop;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                            r_sym <= enc4b5b(crc_nibble(w_crc_out, r_cnt + 3'd1));
                        end
                    end
                end
`endif
                StEop: begin
                    if (w_acc) begin
                        r_vld        <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_vld   <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign enc2ser_sym_vld        = r_vld;
    assign enc2ser_sym            = r_sym;
    assign phy2pl_tx_payload_done = r_done;
    assign phy2pl_tx_frame_done   = r_frame_done;

endmodule
